// File: rtl/pe_os_acc_pkg.sv
// Shared definitions for the output-stationary PE: FSM encoding and sizing helpers.
package pe_os_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2,
    ST_FWD   = 2'd3
  } pe_state_e;

  // Drain counter holds 0..n-1 forwarded transfers; always at least one bit wide.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pe_os_acc_sat_acc.sv
// Registered signed accumulator with saturate/wrap selection and an overflow strobe.
module pe_sat_acc #(
  parameter int ACC_WIDTH = 40,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [ACC_WIDTH-1:0] addend_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [ACC_WIDTH:0] s);
    if (SATURATE && (s[ACC_WIDTH] != s[ACC_WIDTH-1])) begin
      return s[ACC_WIDTH] ? MIN_V : MAX_V;
    end
    return s[ACC_WIDTH-1:0];
  endfunction

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH:0]   base_p0;
  logic signed [ACC_WIDTH:0]   sum_p0;

  // One guard bit: a mismatch between the top two sum bits is a range overflow.
  assign base_p0 = load_i ? '0 : {acc_q[ACC_WIDTH-1], acc_q};
  assign sum_p0  = base_p0 + $signed({addend_i[ACC_WIDTH-1], addend_i});
  assign ovf_o   = en_i & (sum_p0[ACC_WIDTH] ^ sum_p0[ACC_WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= clamp(sum_p0);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/pe_os_acc.sv
// Output-stationary systolic PE: local MAC accumulator, a/b forwarding and a column drain chain.
module pe_os_acc
  import pe_os_acc_pkg::*;
#(
  parameter int ACT_WIDTH = 16,
  parameter int WGT_WIDTH = 16,
  parameter int ACC_WIDTH = 40,
  parameter bit SATURATE  = 1'b1,
  parameter int ROW_IDX   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ACT_WIDTH-1:0] a_in,
  input  logic                 a_valid_in,
  input  logic [WGT_WIDTH-1:0] b_in,
  input  logic                 b_valid_in,
  input  logic                 acc_first,
  input  logic                 acc_last,
  output logic [ACT_WIDTH-1:0] a_out,
  output logic                 a_valid_out,
  output logic [WGT_WIDTH-1:0] b_out,
  output logic                 b_valid_out,
  input  logic [ACC_WIDTH-1:0] psum_in,
  input  logic                 psum_valid_in,
  output logic                 psum_ready_out,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 ovf_flag,
  output logic                 drop_flag
);

  localparam int               CNT_W    = cnt_width(ROW_IDX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ROW_IDX > 0) ? ROW_IDX - 1 : 0);

  if (ACC_WIDTH < ACT_WIDTH + WGT_WIDTH) begin : g_width_chk
    $error("pe_os_acc: ACC_WIDTH must be >= ACT_WIDTH + WGT_WIDTH");
  end

  pe_state_e                   state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        ovf_q;
  logic                        drop_q;
  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;
  logic [ACC_WIDTH-1:0]        acc;
  logic                        fire;
  logic                        accept;
  logic                        load;
  logic                        sum_ovf;

  // Operands widened first so the product is exact in the accumulator width.
  assign a_ext  = ACC_WIDTH'($signed(a_in));
  assign b_ext  = ACC_WIDTH'($signed(b_in));
  assign prod   = a_ext * b_ext;

  assign fire   = a_valid_in & b_valid_in;
  assign accept = fire & ((state_q == ST_IDLE) | (state_q == ST_ACCUM));
  assign load   = acc_first | (state_q == ST_IDLE);

  pe_sat_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .SATURATE  (SATURATE)
  ) u_acc (
    .clk      (clk),
    .reset    (reset),
    .en_i     (accept),
    .load_i   (load),
    .addend_i (prod),
    .acc_o    (acc),
    .ovf_o    (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      a_out       <= '0;
      a_valid_out <= 1'b0;
      b_out       <= '0;
      b_valid_out <= 1'b0;
    end else begin
      a_out       <= a_in;
      a_valid_out <= a_valid_in;
      b_out       <= b_in;
      b_valid_out <= b_valid_in;
      ovf_q       <= ovf_q | sum_ovf;
      drop_q      <= drop_q | (a_valid_in ^ b_valid_in) | (fire & ~accept);
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (accept) state_q <= acc_last ? ST_DONE : ST_ACCUM;
        end
        ST_DONE: begin
          if (out_ready) state_q <= (ROW_IDX > 0) ? ST_FWD : ST_IDLE;
        end
        ST_FWD: begin
          if (psum_valid_in && out_ready) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Upstream results pass straight through so the column drains at one word per cycle.
  always_comb begin
    out_valid      = 1'b0;
    out_data       = '0;
    psum_ready_out = 1'b0;
    case (state_q)
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
      end
      ST_FWD: begin
        out_valid      = psum_valid_in;
        out_data       = psum_in;
        psum_ready_out = out_ready;
      end
      default: ;
    endcase
  end

  assign ovf_flag  = ovf_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_pe_os_acc.sv
// Scoreboard bench: a saturating ROW_IDX=2 PE and a wrapping ROW_IDX=0 PE share one stream.
module tb_pe_os_acc;

  localparam int     ROW  = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint MOD  = 64'sd4294967296;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b;
  logic        av, bv, first, last;
  logic [31:0] psum;
  logic        psum_v, ord0;

  logic [15:0] a_o0, b_o0, a_o1, b_o1;
  logic        av_o0, bv_o0, av_o1, bv_o1;
  logic [31:0] d_o0, d_o1;
  logic        v_o0, v_o1, pr0, pr1, ovf0, ovf1, drp0, drp1;

  always #5 clk = ~clk;

  pe_os_acc #(.ACT_WIDTH(16), .WGT_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b1), .ROW_IDX(ROW)) dut0 (
    .clk(clk), .reset(rst_n), .a_in(a), .a_valid_in(av), .b_in(b), .b_valid_in(bv),
    .acc_first(first), .acc_last(last), .a_out(a_o0), .a_valid_out(av_o0), .b_out(b_o0),
    .b_valid_out(bv_o0), .psum_in(psum), .psum_valid_in(psum_v), .psum_ready_out(pr0),
    .out_data(d_o0), .out_valid(v_o0), .out_ready(ord0), .ovf_flag(ovf0), .drop_flag(drp0));

  pe_os_acc #(.ACT_WIDTH(16), .WGT_WIDTH(16), .ACC_WIDTH(32), .SATURATE(1'b0), .ROW_IDX(0)) dut1 (
    .clk(clk), .reset(rst_n), .a_in(a), .a_valid_in(av), .b_in(b), .b_valid_in(bv),
    .acc_first(first), .acc_last(last), .a_out(a_o1), .a_valid_out(av_o1), .b_out(b_o1),
    .b_valid_out(bv_o1), .psum_in(32'd0), .psum_valid_in(1'b0), .psum_ready_out(pr1),
    .out_data(d_o1), .out_valid(v_o1), .out_ready(1'b1), .ovf_flag(ovf1), .drop_flag(drp1));

  int vectors = 0, miscompares = 0;
  longint exp0[$], exp1[$];

  // Reference model: per PE, tile accumulator, in-tile flag, result-pending flag, sticky flags.
  longint macc[2];
  bit     intile[2], busy[2], mdrop[2], movf[2];
  bit     own_pending;
  int     presented, taken, hold_left, hold_cfg;

  logic [15:0] pa, pb;
  logic        pav, pbv, prst;

  task automatic check(input string name, input longint act, input longint expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic longint acc_step(input longint acc, input longint p, input bit sat,
                                      output bit o);
    longint s;
    s = acc + p;
    o = 1'b0;
    if (s > MAXV) begin
      o = 1'b1;
      s = sat ? MAXV : s - MOD;
    end else if (s < MINV) begin
      o = 1'b1;
      s = sat ? MINV : s + MOD;
    end
    return s;
  endfunction

  task automatic model_fire(input int d, input longint p, input bit f, input bit l);
    bit o;
    if (busy[d]) begin
      mdrop[d] = 1'b1;
      return;
    end
    o = 1'b0;
    if (f || !intile[d]) macc[d] = p;
    else macc[d] = acc_step(macc[d], p, d == 0, o);
    if (o) movf[d] = 1'b1;
    if (l) begin
      intile[d] = 1'b0;
      busy[d]   = 1'b1;
      if (d == 0) begin
        exp0.push_back(macc[0]);
        own_pending = 1'b1;
        presented   = 0;
        taken       = 0;
        hold_left   = hold_cfg;
      end else begin
        exp1.push_back(macc[1]);
      end
    end else begin
      intile[d] = 1'b1;
    end
  endtask

  task automatic step(input bit av_, input bit bv_, input logic [15:0] a_, input logic [15:0] b_,
                      input bit f_, input bit l_);
    bit     b0_pre, b1_pre, took;
    longint p;
    av = av_; bv = bv_; a = a_; b = b_; first = f_; last = l_;
    ord0 = (hold_left > 0) ? 1'b0 : ($urandom_range(3) != 0);
    if (hold_left > 0) hold_left--;
    if (busy[0] && !psum_v && presented < ROW && $urandom_range(1) == 1) begin
      psum   = $urandom;
      psum_v = 1'b1;
      presented++;
      exp0.push_back(longint'($signed(psum)));
    end
    @(negedge clk);
    check("out_valid0", v_o0, busy[0] && (own_pending || psum_v));
    check("psum_ready0", pr0, busy[0] && !own_pending && ord0);
    check("out_valid1", v_o1, busy[1]);
    check("psum_ready1", pr1, 0);
    check("drop_flag0", drp0, mdrop[0]);
    check("drop_flag1", drp1, mdrop[1]);
    check("ovf_flag0", ovf0, movf[0]);
    check("ovf_flag1", ovf1, movf[1]);
    b0_pre = busy[0];
    b1_pre = busy[1];
    took   = 1'b0;
    if (av_ ^ bv_) begin
      mdrop[0] = 1'b1;
      mdrop[1] = 1'b1;
    end
    if (av_ && bv_) begin
      p = longint'($signed(a_)) * longint'($signed(b_));
      model_fire(0, p, f_, l_);
      model_fire(1, p, f_, l_);
    end
    if (b1_pre) busy[1] = 1'b0;
    if (b0_pre) begin
      if (own_pending) begin
        if (ord0) own_pending = 1'b0;
      end else if (psum_v && ord0) begin
        took = 1'b1;
        taken++;
        if (taken == ROW) busy[0] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (took) psum_v = 1'b0;
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a = 16'h1234; b = 16'h8765; av = 1'b1; bv = 1'b1;
    first = 1'b1; last = 1'b1; psum = 32'h5A5A5A5A; psum_v = 1'b0; ord0 = 1'b1;
    @(posedge clk);
    #1;
    check("reset_outputs0", (|d_o0) | v_o0 | (|a_o0) | av_o0 | (|b_o0) | bv_o0 | pr0 | ovf0 | drp0, 0);
    check("reset_outputs1", (|d_o1) | v_o1 | (|a_o1) | av_o1 | (|b_o1) | bv_o1 | pr1 | ovf1 | drp1, 0);
    rst_n = 1'b1; av = 1'b0; bv = 1'b0; first = 1'b0; last = 1'b0;
    exp0.delete();
    exp1.delete();
    for (int d = 0; d < 2; d++) begin
      macc[d] = 0; intile[d] = 1'b0; busy[d] = 1'b0; mdrop[d] = 1'b0; movf[d] = 1'b0;
    end
    own_pending = 1'b0; presented = 0; taken = 0; hold_left = 0;
  endtask

  // Drain the saturating PE; random fires sneak in and must be dropped there.
  task automatic drain();
    int n;
    n = 0;
    while (busy[0] && n < 100) begin
      if ($urandom_range(6) == 0)
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      else
        idle_step();
      n++;
    end
    if (busy[0]) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: drain still open after %0d cycles, required 0 pending", n);
      do_reset();
    end
  endtask

  always @(posedge clk) begin
    pa <= a; pav <= av; pb <= b; pbv <= bv; prst <= rst_n;
  end

  // Monitor: forwarding echo plus scoreboard pops on every presented drain word.
  always @(negedge clk) begin
    if (prst === 1'b1) begin
      check("a_out0", a_o0, pa);   check("a_valid_out0", av_o0, pav);
      check("b_out0", b_o0, pb);   check("b_valid_out0", bv_o0, pbv);
      check("a_out1", a_o1, pa);   check("b_out1", b_o1, pb);
    end
    if (v_o0 === 1'b1) begin
      if (exp0.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL out_data0: got %0d with out_valid, required no output", $signed(d_o0));
      end else begin
        check("out_data0", longint'($signed(d_o0)), exp0[0]);
        if (ord0) void'(exp0.pop_front());
      end
    end
    if (v_o1 === 1'b1) begin
      if (exp1.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL out_data1: got %0d with out_valid, required no output", $signed(d_o1));
      end else begin
        check("out_data1", longint'($signed(d_o1)), exp1.pop_front());
      end
    end
  end

  initial begin
    int len;
    bit f;
    psum_v = 1'b0;
    hold_cfg = 0;
    do_reset();
    do_reset();

    hold_cfg = 3;
    step(1'b1, 1'b1, 16'd2, 16'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'hFFFC, 16'd5, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'd7, 16'hFFFF, 1'b0, 1'b1);
    drain();

    hold_cfg = 2;
    step(1'b1, 1'b1, 16'hFFFD, 16'hFFFD, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'd1, 16'd1, 1'b1, 1'b1);
    drain();

    hold_cfg = 1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h7FFF, 16'h7FFF, i == 0, i == 2);
    drain();

    step(1'b1, 1'b0, 16'd5, 16'd5, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd6, 16'd6, 1'b0, 1'b0);
    idle_step();

    step(1'b1, 1'b1, 16'd9, 16'd9, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'd2, 16'd2, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 16'd3, 16'd4, 1'b0, 1'b1);
    drain();

    for (int t = 0; t < 16; t++) begin
      hold_cfg = $urandom_range(2);
      len = $urandom_range(5, 1);
      for (int e = 0; e < len; e++) begin
        while ($urandom_range(3) == 0) begin
          if ($urandom_range(7) == 0) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
          else idle_step();
        end
        f = (e == 0) ? ($urandom_range(4) != 0) : ($urandom_range(9) == 0);
        step(1'b1, 1'b1, 16'($urandom), 16'($urandom), f, e == len - 1);
      end
      drain();
    end

    for (int i = 0; i < 3; i++) idle_step();
    check("exp0_left", exp0.size(), 0);
    check("exp1_left", exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
